burst_grant_mux: RTL and testbench
==================================

// Module: burst_grant_mux
// PURPOSE
//   Downstream consumer of the priority arbiter's one-hot grant vector. Locks bus ownership
//   to the granted master for a full burst of m_len+1 beats. Routes that master's
//   valid/data onto a single shared output channel and its ready back to it. Flags
//   malformed (multi-hot) grants and signals burst completion so the system can re-arbitrate.
// PARAMETERS
//   num_master  4  number of masters; width of grant/valid/ready vectors (matches arbiter)
//   data_w      8  data width per master and of out_data
//   len_w       4  width of per-master burst length field (beats-1)
// PORTS
//   clk        in   1                 system clock, rising edge
//   rst        in   1                 asynchronous reset, active-high
//   grant      in   num_master        one-hot grant from arbiter; all-zero = no grant
//   m_valid    in   num_master        per-master beat valid
//   m_data     in   num_master*data_w master i data at [i*data_w +: data_w]
//   m_len      in   num_master*len_w  master i burst length-1 at [i*len_w +: len_w]
//   m_ready    out  num_master        per-master ready; only owner bit may be 1
//   out_valid  out  1                 shared channel valid
//   out_data   out  data_w            shared channel data
//   out_ready  in   1                 shared channel ready from sink
//   owner      out  num_master        registered one-hot owner; 0 when idle
//   busy       out  1                 1 while in XFER
//   done       out  1                 1-cycle pulse, cycle after final beat
//   grant_err  out  1                 1-cycle pulse, multi-hot grant sampled in IDLE
// BEHAVIOUR
//   - Reset (async, any time incl. mid-burst): state=IDLE, owner=0, beat count=0,
//     done=0, grant_err=0. Burst aborted; no partial-completion done pulse.
//   - Outputs forced to 0 in IDLE: out_valid, out_data, m_ready.
//   - IDLE transitions:
//     - grant one-hot: latch owner<=grant, cnt<=m_len[owner] -> XFER at next edge.
//     - grant==0: stay IDLE.
//     - grant multi-hot: stay IDLE, grant_err=1 next cycle; owner unchanged (0).
//   - XFER, combinational from registered owner:
//     out_valid = m_valid[k]; out_data = m_data[k]; m_ready[k] = out_ready; others 0.
//   - Beat = out_valid & out_ready.
//     - Beat with cnt!=0: cnt<=cnt-1.
//     - Beat with cnt==0: state<=IDLE, owner<=0, done<=1 for one cycle.
//     - No beat: hold all state; stalls unbounded.
//   - Grant changes while busy are ignored. m_len is sampled only at lock.
//   - Latency:
//     - grant sampled at edge N -> busy=1 and first beat possible in cycle N+1.
//     - Burst of L+1 beats with no stalls occupies L+1 cycles.
//     - done is high in the cycle after the last beat; busy=0 that same cycle.
//   - Re-lock: in the done cycle the block is IDLE and samples grant, so back-to-back
//     bursts are separated by exactly one idle cycle.
//   - cnt is len_w bits, no wrap: m_len=all-ones gives 2^len_w beats; m_len=0 gives 1 beat.
// TESTING
//   1 grant=0100, m_len[2]=3, m_valid=1111, out_ready=1 -> owner=0100; 4 beats carrying
//     m_data[2]; m_ready=0100 during them; done pulse next cycle; busy=0.
//   2 grant=0010, m_len[1]=2, out_ready toggles 1,0,1,0,1 -> exactly 3 beats, done after
//     the 3rd accepted beat; stalled cycles hold out_data stable.
//   3 grant=0110 in IDLE -> grant_err=1 one cycle, busy stays 0, m_ready=0000.
//   4 Lock master 0 (len 5); change grant to 1000 mid-burst -> owner stays 0001 until done;
//     with grant still 1000 in the done cycle, owner=1000 next cycle.
//   5 Assert rst after 2 beats of a 4-beat burst -> same cycle: busy=0, owner=0,
//     out_valid=0, m_ready=0; no done pulse; after release, IDLE.
//   6 m_len=1111 (len_w=4) -> 16 beats before done; m_len=0 -> single beat then done.

Source files
------------

// File: rtl/burst_grant_mux.sv
// Burst ownership lock behind a one-hot arbiter grant.
// Routes the owning master onto one shared channel for m_len+1 beats.
module burst_grant_mux #(
    parameter int num_master = 4,
    parameter int data_w     = 8,
    parameter int len_w      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [num_master-1:0]        grant,
    input  logic [num_master-1:0]        m_valid,
    input  logic [num_master*data_w-1:0] m_data,
    input  logic [num_master*len_w-1:0]  m_len,
    output logic [num_master-1:0]        m_ready,
    output logic                         out_valid,
    output logic [data_w-1:0]            out_data,
    input  logic                         out_ready,
    output logic [num_master-1:0]        owner,
    output logic                         busy,
    output logic                         done,
    output logic                         grant_err
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [num_master-1:0] G_ONE = num_master'(1);
    localparam logic [len_w-1:0]      L_ONE = len_w'(1);

    state_t                  state_q, state_d;
    logic [num_master-1:0]   owner_q, owner_d;
    logic [len_w-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    multi_hot;
    logic [len_w-1:0]        len_sel;
    logic                    sel_valid;
    logic [data_w-1:0]       sel_data;
    logic                    beat;

    // Clearing the lowest set bit leaves a residue only for multi-hot grants.
    assign multi_hot = |(grant & (grant - G_ONE));

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < num_master; i++) begin
            if (grant[i]) begin
                len_sel = len_sel | m_len[i*len_w +: len_w];
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < num_master; i++) begin
            if (owner_q[i]) begin
                sel_valid = sel_valid | m_valid[i];
                sel_data  = sel_data | m_data[i*data_w +: data_w];
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        m_ready   = '0;
        if (state_q == XFER) begin
            out_valid = sel_valid;
            out_data  = sel_data;
            m_ready   = owner_q & {num_master{out_ready}};
        end
    end

    assign beat = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (multi_hot) begin
                    err_d = 1'b1;
                end else if (|grant) begin
                    owner_d = grant;
                    cnt_d   = len_sel;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        owner_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - L_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign owner     = owner_q;
    assign busy      = (state_q == XFER);
    assign done      = done_q;
    assign grant_err = err_q;

endmodule

// File: tb/tb_burst_grant_mux.sv
// Directed bench for burst_grant_mux.
// Expected values are hand-derived per scenario.
module tb_burst_grant_mux;

    localparam int NM = 4;
    localparam int DW = 8;
    localparam int LW = 4;

    logic              clk;
    logic              rst;
    logic [NM-1:0]     grant;
    logic [NM-1:0]     m_valid;
    logic [NM*DW-1:0]  m_data;
    logic [NM*LW-1:0]  m_len;
    logic [NM-1:0]     m_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic [NM-1:0]     owner;
    logic              busy;
    logic              done;
    logic              grant_err;

    int n_cmp;
    int n_err;

    burst_grant_mux #(
        .num_master (NM),
        .data_w     (DW),
        .len_w      (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .grant     (grant),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_len     (m_len),
        .m_ready   (m_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .owner     (owner),
        .busy      (busy),
        .done      (done),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_len(input int m, input logic [LW-1:0] l);
        m_len[m*LW +: LW] = l;
    endtask

    int nb;
    bit hit;
    bit pat [5];

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        grant     = '0;
        m_valid   = 4'b1111;
        out_ready = 1'b1;
        m_len     = '0;
        for (int i = 0; i < NM; i++) m_data[i*DW +: DW] = 8'hA0 + 8'(i);
        #12;
        chk("rst_busy",  32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(grant_err), 0);
        chk("rst_oval",  32'(out_valid), 0);
        chk("rst_mrdy",  32'(m_ready), 0);
        rst = 1'b0;
        step();
        chk("idle_odata", 32'(out_data), 0);

        // 1: grant 0100, len 3, 4 beats
        set_len(2, 4'd3);
        grant = 4'b0100;
        #1;
        chk("t1_prebusy", 32'(busy), 0);
        step();
        grant = '0;
        chk("t1_busy",  32'(busy), 1);
        chk("t1_owner", 32'(owner), 32'h4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_oval",  32'(out_valid), 1);
            chk("t1_odata", 32'(out_data), 32'hA2);
            chk("t1_mrdy",  32'(m_ready), 32'h4);
            chk("t1_nodone", 32'(done), 0);
            step();
        end
        chk("t1_done",  32'(done), 1);
        chk("t1_idle",  32'(busy), 0);
        chk("t1_own0",  32'(owner), 0);
        step();
        chk("t1_pulse", 32'(done), 0);

        // 2: grant 0010, len 2, ready toggling
        set_len(1, 4'd2);
        grant = 4'b0010;
        step();
        grant = '0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            out_ready = pat[k];
            #1;
            chk("t2_busy",  32'(busy), 1);
            chk("t2_odata", 32'(out_data), 32'hA1);
            chk("t2_mrdy",  32'(m_ready), pat[k] ? 32'h2 : 32'h0);
            chk("t2_nodone", 32'(done), 0);
            step();
        end
        out_ready = 1'b1;
        chk("t2_done", 32'(done), 1);
        chk("t2_idle", 32'(busy), 0);

        // 3: multi-hot grant
        step();
        grant = 4'b0110;
        step();
        grant = '0;
        chk("t3_err",   32'(grant_err), 1);
        chk("t3_busy",  32'(busy), 0);
        chk("t3_mrdy",  32'(m_ready), 0);
        chk("t3_owner", 32'(owner), 0);
        step();
        chk("t3_errpulse", 32'(grant_err), 0);
        chk("t3_still", 32'(busy), 0);

        // 4: grant change mid-burst ignored, re-lock in done cycle
        set_len(0, 4'd5);
        set_len(3, 4'd0);
        grant = 4'b0001;
        step();
        grant = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            chk("t4_owner", 32'(owner), 32'h1);
            chk("t4_odata", 32'(out_data), 32'hA0);
            step();
        end
        chk("t4_done",  32'(done), 1);
        chk("t4_own0",  32'(owner), 0);
        step();
        grant = '0;
        chk("t4_relock", 32'(owner), 32'h8);
        chk("t4_rebusy", 32'(busy), 1);
        chk("t4_redata", 32'(out_data), 32'hA3);
        step();
        chk("t4_redone", 32'(done), 1);

        // 5: async reset mid-burst
        set_len(0, 4'd3);
        grant = 4'b0001;
        step();
        grant = '0;
        step();
        step();
        chk("t5_midbusy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t5_busy",  32'(busy), 0);
        chk("t5_owner", 32'(owner), 0);
        chk("t5_oval",  32'(out_valid), 0);
        chk("t5_mrdy",  32'(m_ready), 0);
        step();
        rst = 1'b0;
        chk("t5_nodone", 32'(done), 0);
        step();
        chk("t5_idle",   32'(busy), 0);
        chk("t5_nodone2", 32'(done), 0);

        // 6: maximum and minimum length
        set_len(2, 4'hF);
        grant = 4'b0100;
        step();
        grant = '0;
        nb = 0;
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                hit = 1'b1;
                break;
            end
            if (out_valid && out_ready) nb++;
            step();
        end
        chk("t6_maxdone",  32'(hit), 1);
        chk("t6_maxbeats", 32'(nb), 16);
        set_len(2, 4'h0);
        grant = 4'b0100;
        step();
        grant = '0;
        chk("t6_minbusy", 32'(busy), 1);
        step();
        chk("t6_mindone", 32'(done), 1);
        chk("t6_minidle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
